sc_reg_multimode: RTL and testbench

Parametrised multi-mode general register for the micro-datapath: the next generation of the plain write-enabled register. It adds parallel load, logical shift, rotate, increment, decrement and synchronous clear, with serial in/out and optional registered status flags. It sits in the datapath wherever a register must also act as a shifter or counter.

---
 rtl/sc_reg_multimode.sv | 133 +++++++++++++
 tb/tb_sc_reg_multimode.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sc_reg_multimode.sv
// rtl/sc_reg_multimode.sv - multi-mode general register: load, shift, rotate, inc/dec, clear
// Define SC_REGMULTI_FLAGS_EN to build the registered Z/N/C/V flags; otherwise they read 0.
module sc_reg_multimode #(
  parameter int                       DATAWIDTH_BUS = 32,
  parameter logic [DATAWIDTH_BUS-1:0] RESET_VALUE   = '0
) (
  input  logic                     SC_RegGENERAL_CLOCK_50,
  input  logic                     SC_RegGENERAL_Reset_InHigh,
  input  logic                     SC_RegMULTI_Clear_InHigh,
  input  logic                     SC_RegMULTI_Enable_InHigh,
  input  logic [2:0]               SC_RegMULTI_Mode_In,
  input  logic                     SC_RegMULTI_SerialIn,
  input  logic [DATAWIDTH_BUS-1:0] SC_RegMULTI_DataBUS_In,
  output logic [DATAWIDTH_BUS-1:0] SC_RegMULTI_DataBUS_Out,
  output logic                     SC_RegMULTI_SerialOut,
  output logic                     SC_RegMULTI_Zero_Out,
  output logic                     SC_RegMULTI_Negative_Out,
  output logic                     SC_RegMULTI_Carry_Out,
  output logic                     SC_RegMULTI_Overflow_Out
);

  localparam int W = DATAWIDTH_BUS;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_data;
  logic [W-1:0] w_next;

  always_comb begin
    w_next = r_data;
    case (SC_RegMULTI_Mode_In)
      MODE_HOLD: w_next = r_data;
      MODE_LOAD: w_next = SC_RegMULTI_DataBUS_In;
      MODE_SHL:  w_next = {r_data[W-2:0], SC_RegMULTI_SerialIn};
      MODE_SHR:  w_next = {SC_RegMULTI_SerialIn, r_data[W-1:1]};
      MODE_ROL:  w_next = {r_data[W-2:0], r_data[W-1]};
      MODE_ROR:  w_next = {r_data[0], r_data[W-1:1]};
      MODE_INC:  w_next = r_data + ONE;
      MODE_DEC:  w_next = r_data - ONE;
      default:   w_next = r_data;
    endcase
  end

  // Clear outranks enable, so it acts even while the register is otherwise held.
  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      r_data <= RESET_VALUE;
    end else if (SC_RegMULTI_Clear_InHigh) begin
      r_data <= RESET_VALUE;
    end else if (SC_RegMULTI_Enable_InHigh) begin
      r_data <= w_next;
    end
  end

  assign SC_RegMULTI_DataBUS_Out = r_data;
  assign SC_RegMULTI_SerialOut   = r_data[W-1];

`ifdef SC_REGMULTI_FLAGS_EN
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic r_zero;
  logic r_negative;
  logic r_carry;
  logic r_overflow;
  logic w_carry;
  logic w_overflow;
  logic w_flag_update;

  always_comb begin
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (SC_RegMULTI_Mode_In)
      MODE_SHL, MODE_ROL: w_carry = r_data[W-1];
      MODE_SHR, MODE_ROR: w_carry = r_data[0];
      MODE_INC: begin
        w_carry    = &r_data;
        w_overflow = (r_data == MAX_POS);
      end
      MODE_DEC: begin
        w_carry    = (r_data == '0);
        w_overflow = (r_data == MIN_NEG);
      end
      default: begin
        w_carry    = 1'b0;
        w_overflow = 1'b0;
      end
    endcase
  end

  // Hold mode leaves the flags alone just like a deasserted enable.
  assign w_flag_update = SC_RegMULTI_Enable_InHigh && (SC_RegMULTI_Mode_In != MODE_HOLD);

  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      r_zero     <= (RESET_VALUE == '0);
      r_negative <= RESET_VALUE[W-1];
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (SC_RegMULTI_Clear_InHigh) begin
      r_zero     <= (RESET_VALUE == '0);
      r_negative <= RESET_VALUE[W-1];
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_flag_update) begin
      r_zero     <= (w_next == '0);
      r_negative <= w_next[W-1];
      r_carry    <= w_carry;
      r_overflow <= w_overflow;
    end
  end

  assign SC_RegMULTI_Zero_Out     = r_zero;
  assign SC_RegMULTI_Negative_Out = r_negative;
  assign SC_RegMULTI_Carry_Out    = r_carry;
  assign SC_RegMULTI_Overflow_Out = r_overflow;
`else
  assign SC_RegMULTI_Zero_Out     = 1'b0;
  assign SC_RegMULTI_Negative_Out = 1'b0;
  assign SC_RegMULTI_Carry_Out    = 1'b0;
  assign SC_RegMULTI_Overflow_Out = 1'b0;
`endif

endmodule

// File: tb/tb_sc_reg_multimode.sv
// tb/tb_sc_reg_multimode.sv - directed self-checking bench for sc_reg_multimode (8-bit, reset 0)
// Flag expectations collapse to 0 unless SC_REGMULTI_FLAGS_EN is defined.
module tb_sc_reg_multimode;

  localparam int W = 8;

`ifdef SC_REGMULTI_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic         sin = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         sout;
  logic         z_o, n_o, c_o, v_o;

  int tests_run = 0;
  int tests_failed = 0;

  sc_reg_multimode #(.DATAWIDTH_BUS(W), .RESET_VALUE(8'h00)) u_dut (
    .SC_RegGENERAL_CLOCK_50    (clk),
    .SC_RegGENERAL_Reset_InHigh(rst),
    .SC_RegMULTI_Clear_InHigh  (clr),
    .SC_RegMULTI_Enable_InHigh (en),
    .SC_RegMULTI_Mode_In       (mode),
    .SC_RegMULTI_SerialIn      (sin),
    .SC_RegMULTI_DataBUS_In    (din),
    .SC_RegMULTI_DataBUS_Out   (dout),
    .SC_RegMULTI_SerialOut     (sout),
    .SC_RegMULTI_Zero_Out      (z_o),
    .SC_RegMULTI_Negative_Out  (n_o),
    .SC_RegMULTI_Carry_Out     (c_o),
    .SC_RegMULTI_Overflow_Out  (v_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_flags(input string tag, input bit z, input bit n, input bit c, input bit v);
    check({tag, ".Z"}, {31'd0, z_o}, {31'd0, z & FLAGS});
    check({tag, ".N"}, {31'd0, n_o}, {31'd0, n & FLAGS});
    check({tag, ".C"}, {31'd0, c_o}, {31'd0, c & FLAGS});
    check({tag, ".V"}, {31'd0, v_o}, {31'd0, v & FLAGS});
  endtask

  // Apply inputs at the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input bit e, input bit c, input logic [2:0] m, input logic [W-1:0] d, input bit s);
    @(negedge clk);
    en   = e;
    clr  = c;
    mode = m;
    din  = d;
    sin  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic [W-1:0] d, input bit s);
    step(1'b1, 1'b0, m, d, s);
  endtask

  initial begin
    #2;
    check("reset.out", {24'd0, dout}, 32'h00);
    check("reset.sout", {31'd0, sout}, 32'd0);
    check_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset between edges
    op(3'b001, 8'h3C, 1'b0);
    check("load3C.out", {24'd0, dout}, 32'h3C);
    check_flags("load3C", 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst.out", {24'd0, dout}, 32'h00);
    check("async_rst.sout", {31'd0, sout}, 32'd0);
    check_flags("async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;

    // Shifts
    op(3'b001, 8'hA5, 1'b0);
    check("loadA5.out", {24'd0, dout}, 32'hA5);
    check("loadA5.sout", {31'd0, sout}, 32'd1);
    check_flags("loadA5", 1'b0, 1'b1, 1'b0, 1'b0);
    op(3'b010, 8'h00, 1'b1);
    check("shl.out", {24'd0, dout}, 32'h4B);
    check("shl.sout", {31'd0, sout}, 32'd0);
    check_flags("shl", 1'b0, 1'b0, 1'b1, 1'b0);
    op(3'b011, 8'h00, 1'b0);
    check("shr.out", {24'd0, dout}, 32'h25);
    check_flags("shr", 1'b0, 1'b0, 1'b1, 1'b0);

    // Increment boundaries
    op(3'b001, 8'h7F, 1'b0);
    op(3'b110, 8'h00, 1'b0);
    check("inc7F.out", {24'd0, dout}, 32'h80);
    check_flags("inc7F", 1'b0, 1'b1, 1'b0, 1'b1);
    op(3'b001, 8'hFF, 1'b0);
    op(3'b110, 8'h00, 1'b0);
    check("incFF.out", {24'd0, dout}, 32'h00);
    check_flags("incFF", 1'b1, 1'b0, 1'b1, 1'b0);

    // Decrement boundaries
    op(3'b001, 8'h80, 1'b0);
    op(3'b111, 8'h00, 1'b0);
    check("dec80.out", {24'd0, dout}, 32'h7F);
    check_flags("dec80", 1'b0, 1'b0, 1'b0, 1'b1);
    op(3'b001, 8'h00, 1'b0);
    op(3'b111, 8'h00, 1'b0);
    check("dec00.out", {24'd0, dout}, 32'hFF);
    check_flags("dec00", 1'b0, 1'b1, 1'b1, 1'b0);

    // Back-to-back decrements from 0xFF
    op(3'b111, 8'h00, 1'b0);
    op(3'b111, 8'h00, 1'b0);
    check("dec_b2b.out", {24'd0, dout}, 32'hFD);
    check_flags("dec_b2b", 1'b0, 1'b1, 1'b0, 1'b0);

    // Rotates and hold
    op(3'b001, 8'h01, 1'b0);
    op(3'b101, 8'h00, 1'b0);
    check("ror.out", {24'd0, dout}, 32'h80);
    check_flags("ror", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'b001, 8'h55, 1'b0);
      check($sformatf("en0_%0d.out", i), {24'd0, dout}, 32'h80);
      check_flags($sformatf("en0_%0d", i), 1'b0, 1'b1, 1'b1, 1'b0);
    end
    op(3'b000, 8'h55, 1'b1);
    check("mode_hold.out", {24'd0, dout}, 32'h80);
    check_flags("mode_hold", 1'b0, 1'b1, 1'b1, 1'b0);
    op(3'b100, 8'h00, 1'b1);
    check("rol.out", {24'd0, dout}, 32'h01);
    check_flags("rol", 1'b0, 1'b0, 1'b1, 1'b0);

    // Clear outranks load and enable
    op(3'b001, 8'hC3, 1'b0);
    step(1'b1, 1'b1, 3'b001, 8'hAA, 1'b0);
    check("clear.out", {24'd0, dout}, 32'h00);
    check_flags("clear", 1'b1, 1'b0, 1'b0, 1'b0);
    op(3'b111, 8'h00, 1'b0);
    step(1'b0, 1'b1, 3'b110, 8'h00, 1'b0);
    check("clear_en0.out", {24'd0, dout}, 32'h00);
    check_flags("clear_en0", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
